// File: rtl/mem_data_arbiter.sv
// rtl/mem_data_arbiter.sv - round-robin arbiter sharing one single-port data memory between two requesters
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   reqN, weN, addrN,        port N request, write enable, address, write data,
//   wdataN, lockN            and lock (keep ownership after the current grant)
//   gntN                     port N access accepted this cycle (combinational)
//   rvalidN                  port N read data valid on rdata (cycle after a read grant)
//   rdata                    shared read data, straight from mem_Q
//   mem_A, mem_W, mem_D      memory address, write strobe, write data
//   mem_Q                    memory read data (1-cycle synchronous read)
module mem_data_arbiter #(
    parameter int ADDR = 16,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            we0,
    input  logic [ADDR-1:0] addr0,
    input  logic [WORD-1:0] wdata0,
    input  logic            lock0,
    output logic            gnt0,
    output logic            rvalid0,
    input  logic            req1,
    input  logic            we1,
    input  logic [ADDR-1:0] addr1,
    input  logic [WORD-1:0] wdata1,
    input  logic            lock1,
    output logic            gnt1,
    output logic            rvalid1,
    output logic [WORD-1:0] rdata,
    output logic [ADDR-1:0] mem_A,
    output logic            mem_W,
    output logic [WORD-1:0] mem_D,
    input  logic [WORD-1:0] mem_Q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            last, last_nxt;   // port granted most recently
    logic            win0, win1;
    logic            rv0_q, rv1_q;
    logic [ADDR-1:0] a_q;              // mirror of the last driven address
    logic [WORD-1:0] d_q;              // mirror of the last driven write data

    always_comb begin
        win0      = 1'b0;
        win1      = 1'b0;
        state_nxt = state;
        last_nxt  = last;

        case (state)
            OWN0: win0 = req0;
            OWN1: win1 = req1;
            default: begin
                if (req0 && req1) begin
                    // last == 1 means port 1 went last, so port 0 wins now
                    win0 = last;
                    win1 = !last;
                end else begin
                    win0 = req0;
                    win1 = req1;
                end
            end
        endcase

        if (win0) begin
            last_nxt  = 1'b0;
            state_nxt = lock0 ? OWN0 : IDLE;
        end else if (win1) begin
            last_nxt  = 1'b1;
            state_nxt = lock1 ? OWN1 : IDLE;
        end else if (state == OWN0 && !lock0) begin
            state_nxt = IDLE;
        end else if (state == OWN1 && !lock1) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            a_q   <= '0;
            d_q   <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            rv0_q <= win0 && !we0;
            rv1_q <= win1 && !we1;
            if (win0) begin
                a_q <= addr0;
                d_q <= wdata0;
            end else if (win1) begin
                a_q <= addr1;
                d_q <= wdata1;
            end
        end
    end

    // Grant path is combinational, so it is gated by rst to drop at once on reset.
    assign gnt0    = rst && win0;
    assign gnt1    = rst && win1;
    assign mem_W   = rst && ((win0 && we0) || (win1 && we1));
    assign mem_A   = !rst ? '0 : win0 ? addr0  : win1 ? addr1  : a_q;
    assign mem_D   = !rst ? '0 : win0 ? wdata0 : win1 ? wdata1 : d_q;
    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata   = mem_Q;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb/tb_mem_data_arbiter.sv - self-checking bench for mem_data_arbiter
module tb_mem_data_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic [31:0] wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_W;
    logic [31:0] rdata, mem_D;
    logic [15:0] mem_A;
    logic [31:0] mem_Q = '0;

    int errors = 0;
    int checks = 0;

    mem_data_arbiter #(.ADDR(16), .WORD(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
    );

    always #5 clk = ~clk;

    // Memory device: synchronous read, Q held on write cycles.
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_W) mem[mem_A[7:0]] <= mem_D;
        else       mem_Q <= mem[mem_A[7:0]];
    end

    // Reference model: owner (-1 none), last granted port, pending read, data image.
    int          m_own = -1;
    int          m_last = 1;
    int          m_pend = -1;
    logic [31:0] m_pdata = '0;
    logic [15:0] m_a = '0;
    logic [31:0] m_d = '0;
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    function automatic int exp_win();
        if (m_own == 0) return req0 ? 0 : -1;
        if (m_own == 1) return req1 ? 1 : -1;
        if (req0 && req1) return (m_last == 1) ? 0 : 1;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own <= -1; m_last <= 1; m_pend <= -1; m_pdata <= '0; m_a <= '0; m_d <= '0;
        end else begin
            case (exp_win())
                0: begin
                    m_last <= 0; m_own <= lock0 ? 0 : -1; m_a <= addr0; m_d <= wdata0;
                    if (we0) begin ref_mem[addr0[7:0]] <= wdata0; m_pend <= -1; end
                    else begin m_pend <= 0; m_pdata <= ref_mem[addr0[7:0]]; end
                end
                1: begin
                    m_last <= 1; m_own <= lock1 ? 1 : -1; m_a <= addr1; m_d <= wdata1;
                    if (we1) begin ref_mem[addr1[7:0]] <= wdata1; m_pend <= -1; end
                    else begin m_pend <= 1; m_pdata <= ref_mem[addr1[7:0]]; end
                end
                default: begin
                    m_pend <= -1;
                    if ((m_own == 0 && !lock0) || (m_own == 1 && !lock1)) m_own <= -1;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic test_reset();
        #1 rst = 0;
        req0 = 1; we0 = 1; addr0 = 16'h33; wdata0 = 32'h55; req1 = 1;
        #2;
        checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
        checks++; if (mem_W !== 1'b0) begin errors++; $display("FAIL reset_mem_W: got %b expected 0", mem_W); end
        checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
        checks++; if (mem_A !== 16'h0) begin errors++; $display("FAIL reset_mem_A: got %h expected 0", mem_A); end
        checks++; if (mem_D !== 32'h0) begin errors++; $display("FAIL reset_mem_D: got %h expected 0", mem_D); end
        @(negedge clk);
        rst = 1;
        idle_inputs();
        tick();
    endtask

    task automatic test_write_read();
        req0 = 1; we0 = 1; addr0 = 16'h10; wdata0 = 32'hCAFEBABE;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0: got %b expected 1", gnt0); end
        checks++; if (mem_W !== 1'b1) begin errors++; $display("FAIL wr_mem_W: got %b expected 1", mem_W); end
        checks++; if (mem_D !== 32'hCAFEBABE) begin errors++; $display("FAIL wr_mem_D: got %h expected cafebabe", mem_D); end
        tick();
        we0 = 0;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0: got %b expected 1", gnt0); end
        checks++; if (mem_W !== 1'b0) begin errors++; $display("FAIL rd_mem_W: got %b expected 0", mem_W); end
        checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 00", {rvalid0, rvalid1}); end
        tick();
        req0 = 0;
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b expected 10", {rvalid0, rvalid1}); end
        checks++; if (rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL rd_rdata: got %h expected cafebabe", rdata); end
        tick();
    endtask

    task automatic test_round_robin();
        logic e0;
        rst = 0;
        #2 rst = 1;
        req0 = 1; we0 = 0; addr0 = 16'h10;
        req1 = 1; we1 = 0; addr1 = 16'h21;
        for (int i = 0; i < 4; i++) begin
            e0 = (i % 2 == 0);
            @(negedge clk);
            checks++; if ({gnt0, gnt1} !== {e0, !e0}) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {e0, !e0}); end
            checks++; if ({rvalid0, rvalid1} !== ((i == 0) ? 2'b00 : {!e0, e0})) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b", i, {rvalid0, rvalid1}); end
            if (i > 0 && !e0) begin
                checks++; if (rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected cafebabe", i, rdata); end
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        checks++; if ({rvalid0, rvalid1} !== 2'b01) begin errors++; $display("FAIL rr_last_rvalid: got %b expected 01", {rvalid0, rvalid1}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rr_last_rdata: got %h expected 0", rdata); end
        tick();
    endtask

    task automatic test_lock();
        req0 = 1; we0 = 0; addr0 = 16'h10;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL lock_pre_gnt0: got %b expected 1", gnt0); end
        tick();
        req1 = 1; we1 = 0; addr1 = 16'h10; lock1 = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) lock1 = 0;
            @(negedge clk);
            checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL lock_gnt1[%0d]: got %b expected 01", i, {gnt0, gnt1}); end
            tick();
        end
        req1 = 0;
        @(negedge clk);
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL lock_release: got %b expected 10", {gnt0, gnt1}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_wr_rd_cross();
        req1 = 1; we1 = 1; addr1 = 16'h5; wdata1 = 32'h1234;
        @(negedge clk);
        checks++; if ({gnt1, mem_W} !== 2'b11) begin errors++; $display("FAIL cross_wr: got %b expected 11", {gnt1, mem_W}); end
        tick();
        idle_inputs();
        req0 = 1; we0 = 0; addr0 = 16'h5;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL cross_rd_gnt: got %b expected 1", gnt0); end
        tick();
        req0 = 0;
        @(negedge clk);
        checks++; if (rvalid0 !== 1'b1) begin errors++; $display("FAIL cross_rvalid0: got %b expected 1", rvalid0); end
        checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL cross_rdata: got %h expected 1234", rdata); end
        tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1; we0 = 0; addr0 = 16'h5;
        @(negedge clk);
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rm_gnt0: got %b expected 1", gnt0); end
        tick();
        req0 = 0; req1 = 1; we1 = 1; addr1 = 16'h7; wdata1 = 32'hA5A5A5A5; lock1 = 1;
        #2;
        checks++; if ({rvalid0, mem_W} !== 2'b11) begin errors++; $display("FAIL rm_before: got %b expected 11", {rvalid0, mem_W}); end
        rst = 0;
        #1;
        checks++; if ({rvalid0, mem_W, gnt1} !== 3'b000) begin errors++; $display("FAIL rm_async: got %b expected 000", {rvalid0, mem_W, gnt1}); end
        checks++; if (mem_A !== 16'h0) begin errors++; $display("FAIL rm_mem_A: got %h expected 0", mem_A); end
        @(negedge clk);
        rst = 1;
        req0 = 1; we0 = 0; addr0 = 16'h5;
        #1;
        checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rm_first_contend: got %b expected 10", {gnt0, gnt1}); end
        tick();
        req0 = 0;
        @(negedge clk);
        checks++; if ({gnt1, rvalid0} !== 2'b11) begin errors++; $display("FAIL rm_after: got %b expected 11", {gnt1, rvalid0}); end
        checks++; if (rdata !== 32'h1234) begin errors++; $display("FAIL rm_rdata: got %h expected 1234", rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_idle();
        logic [84:0] obs, ex;
        int w;
        idle_inputs();
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            obs = {gnt0, gnt1, mem_W, rvalid0, rvalid1, mem_A, mem_D, 32'h0};
            ex  = {5'b0, m_a, m_d, 32'h0};
            checks++; if (obs !== ex) begin errors++; $display("FAIL idle[%0d]: got %h expected %h", i, obs, ex); end
            tick();
        end
        req0 = 1; req1 = 1;
        @(negedge clk);
        w = exp_win();
        checks++; if ({gnt0, gnt1} !== {w == 0, w == 1}) begin errors++; $display("FAIL idle_exit: got %b expected %b", {gnt0, gnt1}, {w == 0, w == 1}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [84:0] obs, ex;
        logic [15:0] ea;
        logic [31:0] ed, erd, ord;
        int w;
        int pw = -1;
        for (int c = 0; c < 400; c++) begin
            if (!(req0 && pw != 0)) begin
                req0 = ($urandom_range(0, 2) != 0); we0 = $urandom_range(0, 1);
                addr0 = 16'($urandom_range(0, 15)); wdata0 = $urandom; lock0 = ($urandom_range(0, 3) == 0);
            end
            if (!(req1 && pw != 1)) begin
                req1 = ($urandom_range(0, 2) != 0); we1 = $urandom_range(0, 1);
                addr1 = 16'($urandom_range(0, 15)); wdata1 = $urandom; lock1 = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            w   = exp_win();
            ea  = (w == 0) ? addr0 : (w == 1) ? addr1 : m_a;
            ed  = (w == 0) ? wdata0 : (w == 1) ? wdata1 : m_d;
            erd = (m_pend >= 0) ? m_pdata : 32'h0;
            ord = (m_pend >= 0) ? rdata : 32'h0;
            obs = {gnt0, gnt1, mem_W, rvalid0, rvalid1, mem_A, mem_D, ord};
            ex  = {w == 0, w == 1, (w == 0 && we0) || (w == 1 && we1), m_pend == 0, m_pend == 1, ea, ed, erd};
            checks++; if (obs !== ex) begin errors++; $display("FAIL random[%0d]: got %h expected %h", c, obs, ex); end
            pw = w;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock();
        test_wr_rd_cross();
        test_reset_mid();
        test_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_data_arbiter.md
Name: mem_data_arbiter

Overview:
- Two-port arbiter that shares the single-port data memory between requester 0 (CPU load/store unit) and requester 1 (debug/loader port).
- The memory has a synchronous read with 1-cycle latency, and either a write or a read occurs per cycle, never both. Q holds its value across write cycles.
- The arbiter issues at most one memory access per cycle, grants round-robin, and supports a per-port lock for back-to-back bursts.
- It routes each read result back to the requester that issued it.

Parameters:
- ADDR, 16, memory address width.
- WORD, 32, data word width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR  port 0 address.
- wdata0  in  WORD  port 0 write data.
- lock0  in  1  port 0 holds ownership after its current grant.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid on rdata.
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  WORD  read data, shared by both ports; equals mem_Q.
- mem_A  out  ADDR  memory address.
- mem_W  out  1  memory write strobe.
- mem_D  out  WORD  memory write data.
- mem_Q  in  WORD  memory read data.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - Forced low immediately: gnt0, gnt1, rvalid0, rvalid1, mem_W.
  - mem_A = 0, mem_D = 0.
  - state = IDLE; last = 1, so port 0 wins first.
  - Release takes effect at the first clk edge with rst=1.
- **States:** IDLE, OWN0, OWN1.
  - IDLE: round-robin between ports. If only one port requests, that port wins. If both request, the port that is not `last` wins.
  - OWN0: port 0 is the only candidate; port 1 requests are ignored.
  - OWN1: symmetric to OWN0.
- **Grant (combinational within the cycle):**
  - The winner's gntN = 1.
  - mem_A, mem_D and mem_W are taken from the winner's addrN, wdataN and weN.
  - With no winner: gnt = 0, mem_W = 0, and mem_A/mem_D hold their last driven value (registered mirror).
  - A requester must hold req, we, addr and wdata stable until it sees gnt.
  - One access is accepted per cycle; throughput is 1 access per cycle.
- **State transitions at the edge:**
  - On a grant to N: last <= N. If lockN = 1 the next state is OWNN, otherwise IDLE.
  - In OWNN with reqN = 0 and lockN = 0: return to IDLE.
  - In OWNN with lockN = 0: the current grant is the final one and the next state is IDLE.
  - Lock is sampled only in the cycle of a grant or while owning.
- **Read return:**
  - A read granted in cycle t gives rvalidN = 1 in cycle t+1 only, with rdata = mem_Q.
  - A write grant produces no rvalid.
  - rvalid0 and rvalid1 are never both 1.
  - A read in cycle t+1 may be granted to either port while rvalid for cycle t is presented.
- **No-overlap invariant:** gnt0 and gnt1 are never both 1.
- **Write then read to the same address:** back-to-back issue is allowed. The memory orders them, so the read returns the new data.
- **Reset mid-operation:** a pending rvalid is dropped, ownership is cleared, and a lock held at reset is ignored.

Test Plan:
1. After reset, req0 write addr=0x10 data=0xCAFEBABE, then req0 read addr=0x10 → gnt0 pulses both cycles, mem_W=1 then 0, rvalid0=1 one cycle after the read grant, rdata=0xCAFEBABE, rvalid1=0 throughout.
2. req0 and req1 reads held for 4 cycles, no lock → gnt0, gnt1, gnt0, gnt1 alternating, starting with port 0. Each rvalid appears on the matching port one cycle after its grant, and gnt0/gnt1 are never high together.
3. lock1=1 with req1 for 3 cycles while req0 is held → gnt1 for 3 consecutive cycles. When lock1=0 and req1=0, port 0 is granted in the next cycle.
4. Port 1 writes addr=5 data=0x1234 in cycle t, port 0 reads addr=5 in cycle t+1 → rvalid0 in cycle t+2 with rdata=0x1234.
5. Assert rst=0 asynchronously between edges in the cycle after a read grant → rvalid and mem_W go 0 immediately. After release, the first contended cycle grants port 0.
6. No requests for 5 cycles → gnt=0, mem_W=0, rvalid=0, state stays IDLE.
